// File: rtl/loader_pkg.sv
// Shared types for the Game of Life board row loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// Serial-in/parallel-out shift register; the oldest bit ends up in data[WIDTH-1].
module serial_to_parallel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_reg[gi] <= 1'b0;
            end else if (en) begin
                if (gi == 0) begin
                    data_reg[gi] <= data_in;
                end else begin
                    data_reg[gi] <= data_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/board_row_loader.sv
// Loads a Game of Life board row by row from a serial bit stream and hands
// each completed row, with its index, to the board writer.
module board_row_loader
    import loader_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    output logic [WIDTH-1:0]          row_data,
    output logic [$clog2(HEIGHT)-1:0] row_addr,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(HEIGHT);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

    loader_state_t state_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [AW-1:0] row_idx_reg;
    logic          bit_ready_reg;
    logic          row_valid_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          accept;
    logic          shifter_rst;

    assign accept      = bit_valid && bit_ready_reg;
    assign shifter_rst = ~rst;

    serial_to_parallel #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk    (clk),
        .rst    (shifter_rst),
        .en     (accept),
        .data_in(bit_in),
        .data   (row_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            row_idx_reg   <= '0;
            bit_ready_reg <= 1'b0;
            row_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (abort) begin
            // Abort beats every other event, including a row handshake.
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            row_idx_reg   <= '0;
            bit_ready_reg <= 1'b0;
            row_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= SHIFT;
                        bit_cnt_reg   <= '0;
                        row_idx_reg   <= '0;
                        bit_ready_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg     <= PRESENT;
                            bit_cnt_reg   <= '0;
                            bit_ready_reg <= 1'b0;
                            row_valid_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (row_ready) begin
                        row_valid_reg <= 1'b0;
                        if (row_idx_reg == LAST_ROW) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= SHIFT;
                            row_idx_reg   <= row_idx_reg + 1'b1;
                            bit_ready_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    row_idx_reg <= '0;
                    done_reg    <= 1'b0;
                    busy_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_reg;
    assign row_valid = row_valid_reg;
    assign row_addr  = row_idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_board_row_loader.sv
// Directed testbench for board_row_loader with a 4x2 board.
module tb_board_row_loader;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [WIDTH-1:0] row_data;
    logic [0:0]       row_addr;
    logic             row_valid;
    logic             row_ready;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    board_row_loader #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .row_data (row_data),
        .row_addr (row_addr),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Sends a row MSB first with 'gap' idle cycles between bits; row_valid must stay low until the last bit.
    task automatic send_bits(input logic [WIDTH-1:0] bits, input int first, input int count, input int gap);
        for (int i = first; i < first + count; i++) begin
            bit_in    = bits[WIDTH-1-i];
            bit_valid = 1'b1;
            step();
            bit_valid = 1'b0;
            if (i < WIDTH - 1) begin
                checks++;
                if (row_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_row_valid bit %0d: got %b want 0", i, row_valid);
                end
                for (int g = 0; g < gap; g++) begin
                    step();
                    checks++;
                    if (row_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_row_valid bit %0d: got %b want 0", i, row_valid);
                    end
                end
            end
        end
    endtask

    task automatic check_row(input string name, input logic [WIDTH-1:0] exp_data, input logic exp_addr);
        checks++;
        if (row_valid !== 1'b1 || row_data !== exp_data || row_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%b addr=%0d want valid=1 data=%b addr=%0d",
                     name, row_valid, row_data, row_addr, exp_data, exp_addr);
        end else begin
            $display("row %s: addr=%0d data=%b", name, row_addr, row_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; row_ready = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, bit_ready, row_valid, done, row_data, row_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b bit_ready=%b row_valid=%b done=%b data=%b addr=%0d want all 0",
                     busy, bit_ready, row_valid, done, row_data, row_addr);
        end
        step();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b bit_ready=%b want 0 0", busy, bit_ready);
        end
    endtask

    task automatic test_full_load();
        row_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_shift: got busy=%b bit_ready=%b want 1 1", busy, bit_ready);
        end
        send_bits(4'b1011, 0, 4, 0);
        check_row("full_row0", 4'b1011, 1'b0);
        step();
        checks++;
        if (row_valid !== 1'b0 || bit_ready !== 1'b1 || row_addr !== 1'b1) begin
            errors++;
            $display("FAIL next_row_shift: got valid=%b bit_ready=%b addr=%0d want 0 1 1",
                     row_valid, bit_ready, row_addr);
        end
        send_bits(4'b0110, 0, 4, 0);
        check_row("full_row1", 4'b0110, 1'b1);
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || row_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 1 0", done, busy, row_valid);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || row_addr !== 1'b0) begin
            errors++;
            $display("FAIL done_end: got done=%b busy=%b addr=%0d want 0 0 0", done, busy, row_addr);
        end
        row_ready = 1'b0;
    endtask

    task automatic test_gaps();
        pulse_start();
        send_bits(4'b1101, 0, 4, 2);
        check_row("gap_row0", 4'b1101, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            bit_valid = i[0];
            bit_in    = ~i[1];
            step();
            checks++;
            if (row_valid !== 1'b1 || row_data !== 4'b1101 || bit_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got valid=%b data=%b bit_ready=%b want 1 1101 0",
                         i, row_valid, row_data, bit_ready);
            end
        end
        bit_valid = 1'b0;
        row_ready = 1'b1;
        step();
        row_ready = 1'b0;
        checks++;
        if (row_valid !== 1'b0 || bit_ready !== 1'b1 || row_addr !== 1'b1) begin
            errors++;
            $display("FAIL release_backpressure: got valid=%b bit_ready=%b addr=%0d want 0 1 1",
                     row_valid, bit_ready, row_addr);
        end
    endtask

    task automatic test_abort();
        send_bits(4'b1100, 0, 2, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0 || row_addr !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b bit_ready=%b addr=%0d want 0 0 0", busy, bit_ready, row_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (row_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: got valid=%b done=%b want 0 0", i, row_valid, done);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b bit_ready=%b want 0 0", busy, bit_ready);
        end
        pulse_start();
        send_bits(4'b1001, 0, 4, 0);
        check_row("post_abort_row0", 4'b1001, 1'b0);
        // Abort together with row_ready: the row is not delivered and the board restarts at row 0.
        abort = 1'b1;
        row_ready = 1'b1;
        step();
        abort = 1'b0;
        row_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || row_addr !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_present: got busy=%b valid=%b addr=%0d done=%b want 0 0 0 0",
                     busy, row_valid, row_addr, done);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        pulse_start();
        send_bits(4'b0111, 0, 2, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (row_valid !== 1'b0 || bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_shift: got valid=%b bit_ready=%b want 0 1", row_valid, bit_ready);
        end
        send_bits(4'b0111, 2, 2, 0);
        check_row("start_ignored_row0", 4'b0111, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (row_valid !== 1'b0 || busy !== 1'b0 || row_data !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_present: got valid=%b busy=%b data=%b want 0 0 0000", row_valid, busy, row_data);
        end
        #3 rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0 || row_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: got busy=%b bit_ready=%b valid=%b want 0 0 0",
                     busy, bit_ready, row_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_backpressure();
        test_abort();
        test_start_ignored_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
